// File: rtl/vga_pkg.sv
// Shared types and text codes for the text overlay menu sequencer.
package vga_pkg;

  typedef enum logic [2:0] {
    MENU     = 3'd0,
    SETTINGS = 3'd1,
    GAME     = 3'd2,
    RESULT   = 3'd3,
    ERROR    = 3'd4
  } menu_state_t;

  localparam logic [2:0] TXT_ONE_PLAYER = 3'd0;
  localparam logic [2:0] TXT_TWO_PLAYER = 3'd1;
  localparam logic [2:0] TXT_SETTINGS   = 3'd2;
  localparam logic [2:0] TXT_CONN_ERR   = 3'd3;
  localparam logic [2:0] TXT_BACK       = 3'd4;
  localparam logic [2:0] TXT_WIN        = 3'd5;
  localparam logic [2:0] TXT_LOSE       = 3'd6;
  localparam logic [2:0] TXT_DRAW       = 3'd7;

  // Result code 3 is shown as a draw.
  function automatic logic [2:0] result_text(input logic [1:0] res);
    case (res)
      2'd0:    result_text = TXT_WIN;
      2'd1:    result_text = TXT_LOSE;
      default: result_text = TXT_DRAW;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one debounced button level.
module btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/menu_text_ctrl.sv
// Menu/screen sequencer driving three overlay text lines; display outputs update at frame start.
// Optional MENU_TIMEOUT_EN: RESULT screen auto-returns to MENU after RESULT_FRAMES frames.
module menu_text_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned RESULT_FRAMES = 180,
  parameter logic [11:0] HL_COLOR      = 12'hF00,
  parameter logic [11:0] FONT_COLOR    = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  input  logic        game_over,
  input  logic [1:0]  game_result,
  input  logic        conn_ok,
  output logic [2:0]  line_text  [0:2],
  output logic [2:0]  line_en,
  output logic [11:0] line_color [0:2],
  output logic        game_start,
  output logic        two_player,
  output logic [2:0]  state_o
);

  logic up_rise, down_rise, enter_rise;

  btn_edge u_edge_up    (.clk_i(clk), .rst_i(rst), .btn_i(btn_up),    .rise_o(up_rise));
  btn_edge u_edge_down  (.clk_i(clk), .rst_i(rst), .btn_i(btn_down),  .rise_o(down_rise));
  btn_edge u_edge_enter (.clk_i(clk), .rst_i(rst), .btn_i(btn_enter), .rise_o(enter_rise));

  menu_state_t state_q, state_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [1:0]  result_q, result_d;
  logic        two_player_q, two_player_d;
  logic        game_start_q, game_start_d;
  logic        timeout;

`ifdef MENU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(RESULT_FRAMES + 1);
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;

  // Held at zero outside RESULT, so it is clear on every RESULT entry.
  always_comb begin
    frame_cnt_d = '0;
    if (state_q == RESULT && frame_start) frame_cnt_d = frame_cnt_q + 1'b1;
    else if (state_q == RESULT)           frame_cnt_d = frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign timeout = (state_q == RESULT) && frame_start &&
                   (frame_cnt_q == CntW'(RESULT_FRAMES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    result_d     = result_q;
    two_player_d = two_player_q;
    case (state_q)
      MENU: begin
        if (enter_rise) begin
          case (cursor_q)
            2'd0: begin
              state_d      = GAME;
              two_player_d = 1'b0;
            end
            2'd1: begin
              if (conn_ok) begin
                state_d      = GAME;
                two_player_d = 1'b1;
              end else begin
                state_d = ERROR;
              end
            end
            default: state_d = SETTINGS;
          endcase
        end else if (up_rise && !down_rise) begin
          cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
        end else if (down_rise && !up_rise) begin
          cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
        end
      end
      SETTINGS, ERROR: begin
        if (enter_rise) state_d = MENU;
      end
      GAME: begin
        // Link loss wins over a simultaneous game over.
        if (two_player_q && !conn_ok) begin
          state_d = ERROR;
        end else if (game_over) begin
          state_d  = RESULT;
          result_d = game_result;
        end
      end
      RESULT: begin
        if (enter_rise || timeout) state_d = MENU;
      end
      default: state_d = MENU;
    endcase
    if (state_d == MENU && state_q != MENU) cursor_d = 2'd0;
    game_start_d = (state_d == GAME) && (state_q != GAME);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MENU;
      cursor_q     <= 2'd0;
      result_q     <= 2'd0;
      two_player_q <= 1'b0;
      game_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      result_q     <= result_d;
      two_player_q <= two_player_d;
      game_start_q <= game_start_d;
    end
  end

  assign state_o    = state_q;
  assign game_start = game_start_q;
  assign two_player = two_player_q;

  // Display image of the current state, captured into the shadows only at frame start.
  logic [2:0]  txt_d [0:2];
  logic [2:0]  en_d;
  logic [11:0] col_d [0:2];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      txt_d[i] = TXT_ONE_PLAYER;
      col_d[i] = FONT_COLOR;
    end
    en_d = 3'b000;
    case (state_q)
      MENU: begin
        txt_d[0] = TXT_ONE_PLAYER;
        txt_d[1] = TXT_TWO_PLAYER;
        txt_d[2] = TXT_SETTINGS;
        en_d     = 3'b111;
        for (int i = 0; i < 3; i++) begin
          if (cursor_q == 2'(i)) col_d[i] = HL_COLOR;
        end
      end
      SETTINGS: begin
        txt_d[0] = TXT_BACK;
        en_d     = 3'b001;
        col_d[0] = HL_COLOR;
      end
      RESULT: begin
        txt_d[0] = result_text(result_q);
        txt_d[1] = TXT_BACK;
        en_d     = 3'b011;
        col_d[1] = HL_COLOR;
      end
      ERROR: begin
        txt_d[0] = TXT_CONN_ERR;
        txt_d[1] = TXT_BACK;
        en_d     = 3'b011;
        col_d[1] = HL_COLOR;
      end
      default: en_d = 3'b000;
    endcase
  end

  logic [2:0]  txt_q [0:2];
  logic [2:0]  en_q;
  logic [11:0] col_q [0:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      txt_q[0] <= TXT_ONE_PLAYER;
      txt_q[1] <= TXT_TWO_PLAYER;
      txt_q[2] <= TXT_SETTINGS;
      en_q     <= 3'b111;
      col_q[0] <= HL_COLOR;
      col_q[1] <= FONT_COLOR;
      col_q[2] <= FONT_COLOR;
    end else if (frame_start) begin
      for (int i = 0; i < 3; i++) begin
        txt_q[i] <= txt_d[i];
        col_q[i] <= col_d[i];
      end
      en_q <= en_d;
    end
  end

  assign line_text  = txt_q;
  assign line_color = col_q;
  assign line_en    = en_q;

endmodule

// File: tb/tb_menu_text_ctrl.sv
// Directed self-checking bench for menu_text_ctrl with a queue-based expected-value scoreboard.
module tb_menu_text_ctrl;

  logic        clk = 1'b0;
  logic        rst, frame_start, btn_up, btn_down, btn_enter;
  logic        game_over, conn_ok;
  logic [1:0]  game_result;
  logic [2:0]  line_text  [0:2];
  logic [2:0]  line_en;
  logic [11:0] line_color [0:2];
  logic        game_start, two_player;
  logic [2:0]  state_o;

  menu_text_ctrl #(
    .RESULT_FRAMES(3),
    .HL_COLOR     (12'hF00),
    .FONT_COLOR   (12'h000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_enter  (btn_enter),
    .game_over  (game_over),
    .game_result(game_result),
    .conn_ok    (conn_ok),
    .line_text  (line_text),
    .line_en    (line_en),
    .line_color (line_color),
    .game_start (game_start),
    .two_player (two_player),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty observed=%h required=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic press(input int which);
    if (which == 0) btn_up = 1'b1;
    else if (which == 1) btn_down = 1'b1;
    else btn_enter = 1'b1;
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0;
    tick();
  endtask

  localparam int Up = 0, Down = 1, Enter = 2;

  initial begin
    rst = 1'b1; frame_start = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0;
    game_over = 1'b0; game_result = 2'd0; conn_ok = 1'b1;
    #1;
    tick(); tick();
    rst = 1'b0;

    // Reset image
    push("rst_text0", 0); push("rst_text1", 1); push("rst_text2", 2);
    push("rst_en", 3'b111); push("rst_col0", 12'hF00); push("rst_col1", 12'h000);
    push("rst_col2", 12'h000); push("rst_gs", 0); push("rst_state", 0);
    frame(); frame();
    chk(line_text[0]); chk(line_text[1]); chk(line_text[2]);
    chk(line_en); chk(line_color[0]); chk(line_color[1]); chk(line_color[2]);
    chk(game_start); chk(state_o);

    // Wrap up 0 -> 2
    push("wrap_col2", 12'hF00); push("wrap_col0", 12'h000);
    press(Up); frame();
    chk(line_color[2]); chk(line_color[0]);

    // Down twice 2 -> 0 -> 1
    push("down2_col1", 12'hF00); push("down2_col2", 12'h000);
    press(Down); press(Down); frame();
    chk(line_color[1]); chk(line_color[2]);

    // Held down acts once: 1 -> 2
    push("hold_col2", 12'hF00); push("hold_col0", 12'h000);
    btn_down = 1'b1;
    repeat (100) tick();
    btn_down = 1'b0;
    frame();
    chk(line_color[2]); chk(line_color[0]);

    // Cursor 1 without link -> ERROR
    press(Up);
    conn_ok = 1'b0;
    push("err_state", 4);
    press(Enter);
    chk(state_o);
    push("err_text0", 3); push("err_text1", 4); push("err_col1", 12'hF00);
    push("err_col0", 12'h000);
    frame();
    chk(line_text[0]); chk(line_text[1]); chk(line_color[1]); chk(line_color[0]);

    // Back to MENU (cursor 0), then two-player start with link up
    press(Enter);
    conn_ok = 1'b1;
    press(Down);
    push("tp_gs_pulse", 1); push("tp_state", 2); push("tp_two_player", 1);
    btn_enter = 1'b1;
    tick();
    chk(game_start); chk(state_o); chk(two_player);
    push("tp_gs_low", 0);
    btn_enter = 1'b0;
    tick();
    chk(game_start);
    push("game_en", 3'b000);
    frame();
    chk(line_en);

    // Win result
    push("win_state", 3);
    game_over = 1'b1; game_result = 2'd0;
    tick();
    game_over = 1'b0;
    chk(state_o);
    push("win_text0", 5); push("win_col0", 12'h000); push("win_col1", 12'hF00);
    push("win_en", 3'b011);
    frame();
    chk(line_text[0]); chk(line_color[0]); chk(line_color[1]); chk(line_en);
    push("ret_state", 0); push("ret_col0", 12'hF00); push("ret_text0", 0);
    press(Enter);
    chk(state_o);
    frame();
    chk(line_color[0]); chk(line_text[0]);

    // Link drop coincident with game over -> ERROR
    press(Down);
    press(Enter);
    push("drop_state", 4);
    conn_ok = 1'b0; game_over = 1'b1; game_result = 2'd1;
    tick();
    game_over = 1'b0;
    chk(state_o);
    conn_ok = 1'b1;
    press(Enter);

    // One-player game, draw result (code 3), timeout behaviour
    push("op_two_player", 0);
    press(Enter);
    chk(two_player);
    game_over = 1'b1; game_result = 2'd3;
    tick();
    game_over = 1'b0;
    push("draw_text0", 7);
    frame();
    chk(line_text[0]);
`ifdef MENU_TIMEOUT_EN
    push("to_hold_state", 3);
    frame();
    chk(state_o);
    push("to_exit_state", 0);
    frame();
    chk(state_o);
`else
    push("noto_state", 3);
    repeat (9) frame();
    chk(state_o);
    press(Enter);
`endif

    // Reset mid-game
    press(Enter);
    push("mid_state", 0); push("mid_gs", 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(state_o); chk(game_start);
    push("mid_gs_after", 0);
    tick();
    chk(game_start);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/menu_text_ctrl.md
# menu_text_ctrl

Menu/screen sequencer for the text overlay path. Turns button presses, game-over and link-status events into a screen state machine. Drives the text selection, highlight line and enable for up to three stacked 16-character text lines, plus a game-start pulse and mode to the game core. Display-facing outputs change only at frame start, so a line never switches text mid-frame.

## Interface
Parameters:
- `RESULT_FRAMES`, 180: frames the result screen stays up before auto-return (only with `MENU_TIMEOUT_EN`).
- `HL_COLOR`, 12'hF00: font colour of the highlighted line.
- `FONT_COLOR`, 12'h000: font colour of the other lines.

Ports:
- `clk`  in  1: pixel clock.
- `rst`  in  1: synchronous, active-high reset.
- `frame_start`  in  1: one-cycle pulse at the first vblank cycle.
- `btn_up`, `btn_down`, `btn_enter`  in  1 each: debounced levels, active-high.
- `game_over`  in  1: one-cycle pulse from the game core.
- `game_result`  in  2: 0 win, 1 lose, 2 draw, 3 treated as draw; valid with `game_over`.
- `conn_ok`  in  1: UART link alive.
- `line_text[0:2]`  out  3 each: text code per line (0..7, same numbering as the text ROM set).
- `line_en`  out  3: per-line display enable.
- `line_color[0:2]`  out  12 each: font colour per line.
- `game_start`  out  1: one-cycle pulse on entry to GAME.
- `two_player`  out  1: mode latched at game start.
- `state_o`  out  3: current state, for debug.

## Operation
- Rising edges: `btn_*` are edge-detected (`x & ~x_q`). Only edges act; a held button acts once.
- Priority: enter > up/down. Up and down together are ignored.
- States:
  - **MENU**: lines 0/1/2 = codes 0/1/2, all enabled. `cursor` (0..2) is highlighted.
    - up: `cursor-1`, wrapping 0→2. down: `cursor+1`, wrapping 2→0.
    - enter with cursor 0 → GAME with `two_player`=0.
    - enter with cursor 1 → GAME with `two_player`=1 if `conn_ok`, else ERROR.
    - enter with cursor 2 → SETTINGS.
  - **SETTINGS**: line 0 = code 4 and highlighted; lines 1 and 2 disabled. enter → MENU.
  - **GAME**: `line_en`=000.
    - `game_over` → RESULT, latching `game_result`.
    - if `two_player` and `conn_ok`=0 → ERROR; this takes priority over a `game_over` in the same cycle.
  - **RESULT**: line 0 = code 5/6/7 (win/lose/draw), not highlighted. Line 1 = code 4, highlighted. Line 2 disabled. enter → MENU.
  - **ERROR**: line 0 = code 3; line 1 = code 4, highlighted. enter → MENU.
- Every entry to MENU resets `cursor` to 0.
- `game_over` outside GAME is ignored. `conn_ok` is ignored outside GAME and outside the MENU cursor-1 decision.
- `game_start` pulses for exactly one cycle on the transition into GAME.

## Timing
- Edge registers sample every cycle. A state change lands on the clock edge after the cycle in which the detected edge is high, i.e. 1 cycle after the input rises.
- `state_o`, `game_start` and `two_player` are registered and follow the state immediately.
- `line_text`, `line_en` and `line_color` are shadow registers, loaded on the clock edge after a cycle with `frame_start`=1. Worst-case visible latency is one frame + 1 cycle.
- An event in the same cycle as `frame_start` is not visible at that frame's load. The load uses the pre-event state.
- Reset values:
  - state MENU, cursor 0.
  - `line_text` = 0/1/2, `line_en` = 111.
  - `line_color[0]` = `HL_COLOR`, the others `FONT_COLOR`.
  - `game_start` 0, `two_player` 0, edge registers 0.
  - The result-frame counter is cleared.
- Reset mid-game returns to MENU and emits no `game_start`.

## Configuration
- `MENU_TIMEOUT_EN` defined:
  - RESULT counts `frame_start` pulses from 0.
  - On reaching `RESULT_FRAMES` it goes to MENU on that cycle. Enter still exits early.
  - Counter width is $clog2(RESULT_FRAMES+1). It clears on RESULT entry.
- Not defined: no counter is present and RESULT exits only on enter.

## Structure
- `vga_pkg` holds:
  - `menu_state_t` enum: MENU, SETTINGS, GAME, RESULT, ERROR.
  - Text code constants `TXT_ONE_PLAYER`=0 … `TXT_DRAW`=7.
- One sub-module, `btn_edge`: a 1-bit registered rising-edge detector, instantiated three times.
- The shadow-register load is inline logic.

## Test plan
- Reset, then 2 frames: `line_text`=0/1/2, `line_en`=111, `line_color[0]`=F00 and the others 000, `game_start`=0.
- Wrap-around: up from cursor 0 gives cursor 2, visible after the next `frame_start`. Then down twice gives cursor 1. Holding down for 100 cycles moves only one step.
- Two-player gating: cursor 1 with `conn_ok`=0, enter → ERROR; after a frame the lines show 3/4 with line 1 highlighted. Repeat with `conn_ok`=1 → one `game_start` pulse, `two_player`=1, `line_en`=000.
- Win result: in GAME, `game_over` with result=0 → RESULT, line 0 = 5. Enter → MENU with cursor 0.
- Link drop vs game over: in two-player GAME, drop `conn_ok` in the same cycle as `game_over` → ERROR, not RESULT.
- Timeout with `MENU_TIMEOUT_EN` and `RESULT_FRAMES`=3: RESULT returns to MENU on the 3rd `frame_start`. Without the macro it stays in RESULT after 10 frames.
